iter_comparator: RTL and testbench

ITER_COMPARATOR -- requirements
Module: iter_comparator

---
 rtl/iter_comparator.sv | 133 +++++++++++++
 tb/tb_iter_comparator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_comparator.sv
// Iterative magnitude comparator: scans operands CHUNK bits per cycle, MSB chunk first.
// Optional two's-complement ordering is enabled by defining CMP_SIGNED_EN (adds signed_mode port).
module iter_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] equal_mask,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic             decided;
`ifdef CMP_SIGNED_EN
    logic             signed_r;
`endif

    int unsigned      base_c;
    logic [CHUNK-1:0] ca_c;
    logic [CHUNK-1:0] cb_c;
    logic [CHUNK-1:0] flip_c;
    logic [CHUNK-1:0] xnor_c;
    logic [WIDTH-1:0] mask_c;
    logic             cgt_c;
    logic             cdiff_c;

    // Current chunk extraction, mask merge and chunk ordering
    always_comb begin
        base_c  = 32'(idx) * CHUNK;
        ca_c    = CHUNK'(a_r >> base_c);
        cb_c    = CHUNK'(b_r >> base_c);
        flip_c  = '0;
`ifdef CMP_SIGNED_EN
        // Inverting both sign bits maps two's-complement order onto unsigned order
        if (signed_r && (idx == LAST)) begin
            flip_c = CHUNK'(1) << (CHUNK - 1);
        end
`endif
        xnor_c  = ~(ca_c ^ cb_c);
        mask_c  = (equal_mask & ~(WIDTH'({CHUNK{1'b1}}) << base_c))
                | (WIDTH'(xnor_c) << base_c);
        cgt_c   = (ca_c ^ flip_c) > (cb_c ^ flip_c);
        cdiff_c = (ca_c != cb_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_r        <= '0;
            b_r        <= '0;
            idx        <= '0;
            decided    <= 1'b0;
`ifdef CMP_SIGNED_EN
            signed_r   <= 1'b0;
`endif
            busy       <= 1'b0;
            done       <= 1'b0;
            equal_mask <= '0;
            eq         <= 1'b0;
            gt         <= 1'b0;
            lt         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r        <= a;
                        b_r        <= b;
`ifdef CMP_SIGNED_EN
                        signed_r   <= signed_mode;
`endif
                        idx        <= LAST;
                        decided    <= 1'b0;
                        equal_mask <= '0;
                        eq         <= 1'b0;
                        gt         <= 1'b0;
                        lt         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    equal_mask <= mask_c;
                    // First differing chunk decides; all chunks still scanned for the mask
                    if (!decided && cdiff_c) begin
                        gt      <= cgt_c;
                        lt      <= ~cgt_c;
                        decided <= 1'b1;
                    end
                    if (idx == '0) begin
                        eq    <= ~(decided | cdiff_c);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_comparator.sv
// Randomized self-checking bench for iter_comparator against a whole-word reference model.
module tb_iter_comparator;

    localparam int unsigned W = 8;
    localparam int unsigned C = 2;
    localparam int unsigned N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start1;
    logic         sm;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busy, done, eq, gt, lt;
    logic [W-1:0] mask;
    logic         busy1, done1, eq1, gt1, lt1;
    logic [W-1:0] mask1;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    iter_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef CMP_SIGNED_EN
        .signed_mode(sm),
`endif
        .busy(busy), .done(done), .equal_mask(mask), .eq(eq), .gt(gt), .lt(lt)
    );

    // Single-chunk instance: whole word compared in one scan cycle
    iter_comparator #(.WIDTH(W), .CHUNK(W)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
`ifdef CMP_SIGNED_EN
        .signed_mode(sm),
`endif
        .busy(busy1), .done(done1), .equal_mask(mask1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic e, output logic g, output logic l,
                                  output logic [W-1:0] m);
        m = ~(x ^ y);
        e = (x == y);
        if (s) g = $signed(x) > $signed(y);
        else   g = x > y;
        l = !e && !g;
    endfunction

    task automatic check_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_eq"},   eq,   1'b0);
        chk1({tag, "_gt"},   gt,   1'b0);
        chk1({tag, "_lt"},   lt,   1'b0);
        chkw({tag, "_mask"}, mask, '0);
    endtask

    // One full compare; disturb = SCAN cycle (1..N) in which a busy start is injected, 0 = none
    task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input int disturb);
        logic e, g, l;
        logic [W-1:0] m;
        model(x, y, s, e, g, l, m);
        a = x; b = y; sm = s; start = 1'b1;
        tick();
        for (int c = 1; c <= int'(N); c++) begin
            chk1("scan_busy", busy, 1'b1);
            chk1("scan_done", done, 1'b0);
            if (c == disturb) begin
                start = 1'b1; a = '0; b = '1; sm = ~s;
            end else begin
                start = 1'b0; a = W'($urandom); b = W'($urandom);
            end
            tick();
        end
        chk1("done_pulse", done, 1'b1);
        chk1("done_busy",  busy, 1'b1);
        chk1("res_eq",     eq,   e);
        chk1("res_gt",     gt,   g);
        chk1("res_lt",     lt,   l);
        chkw("res_mask",   mask, m);
        chk1("res_onehot", $onehot({eq, gt, lt}), 1'b1);
        start = 1'b1; a = W'($urandom); b = W'($urandom);
        tick();
        start = 1'b0;
        chk1("post_done", done, 1'b0);
        chk1("post_busy", busy, 1'b0);
        chk1("hold_eq",   eq,   e);
        chk1("hold_gt",   gt,   g);
        chk1("hold_lt",   lt,   l);
        chkw("hold_mask", mask, m);
        tick();
        chk1("idle_after_done_start", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic s;
        int d;

        rst = 1'b1; start = 1'b1; start1 = 1'b1; sm = 1'b0; a = 8'h12; b = 8'h34;
        tick();
        tick();
        check_zero("reset");
        chk1("reset_busy1", busy1, 1'b0);
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        tick();

        run_cmp(8'hA5, 8'hA5, 1'b0, 0);
        run_cmp(8'h3C, 8'h34, 1'b0, 0);
        run_cmp(8'h80, 8'h7F, 1'b0, 0);
`ifdef CMP_SIGNED_EN
        run_cmp(8'h80, 8'h7F, 1'b1, 0);
        run_cmp(8'hFF, 8'h01, 1'b1, 0);
`endif
        run_cmp(8'h3C, 8'h34, 1'b0, 2);

        // Abort during the third SCAN cycle
        a = 8'h55; b = 8'hAA; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("abort");
        for (int i = 0; i < 6; i++) begin
            chk1("abort_no_done", done, 1'b0);
            tick();
        end
        run_cmp(8'h01, 8'h02, 1'b0, 0);

        // Single-chunk configuration: done two cycles after start
        a = 8'h5A; b = 8'h5B; sm = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk1("n1_busy",  busy1, 1'b1);
        chk1("n1_scan_done", done1, 1'b0);
        tick();
        chk1("n1_done",  done1, 1'b1);
        chk1("n1_lt",    lt1,   1'b1);
        chk1("n1_gt",    gt1,   1'b0);
        chk1("n1_eq",    eq1,   1'b0);
        chkw("n1_mask",  mask1, 8'hFE);
        tick();
        chk1("n1_post_done", done1, 1'b0);
        chk1("n1_post_busy", busy1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ W'($urandom_range(1, 3));
                default: y = W'($urandom);
            endcase
            s = 1'b0;
`ifdef CMP_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`endif
            d = int'($urandom_range(0, N));
            run_cmp(x, y, s, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
